// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with per-slot dead time and a
// double-buffered segment word that only swaps at frame boundaries.
module seg_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s,
   input  logic        load,
   input  logic        en,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame,
   output logic        pending
);

   localparam int              CW          = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]   C_LAST      = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]   C_BLANK_END = CW'(BLANK_CYC - 1);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_idx;
   logic [31:0]     r_disp;
   logic [31:0]     r_pend_word;
   logic            r_pending;
   logic            w_wrap;
   logic            w_apply;
   logic [3:0]      w_an;
   logic [7:0]      w_seg;

   assign w_wrap  = (r_cnt == C_LAST);
   // Last cycle of digit 3 is the only point where the shown word may swap.
   assign w_apply = en && w_wrap && (r_idx == 2'd3);
   assign pending = r_pending;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (!en) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_BLANK;
      else     r_state <= w_state_nxt;
   end

   // NOTE: a default assignment ahead of the case keeps this block free of
   // inferred latches on every path.
   always_comb begin
      w_state_nxt = r_state;
      if (!en) begin
         w_state_nxt = ST_BLANK;
      end else begin
         case (r_state)
            ST_BLANK: if (r_cnt == C_BLANK_END) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_wrap)               w_state_nxt = ST_BLANK;
            default:                            w_state_nxt = ST_BLANK;
         endcase
      end
   end

   always_comb begin
      w_an  = 4'b1111;
      w_seg = 8'hFF;
      if (en && r_state == ST_DRIVE) begin
         w_an[r_idx] = 1'b0;
         w_seg       = r_disp[{r_idx, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an    <= 4'b1111;
         seg   <= 8'hFF;
         frame <= 1'b0;
      end else begin
         an    <= w_an;
         seg   <= w_seg;
         frame <= w_apply;
      end
   end

   // A load that coincides with a swap point (or happens while idle) bypasses
   // the pending buffer, since the newest word always wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_disp      <= 32'hFFFF_FFFF;
         r_pend_word <= 32'hFFFF_FFFF;
         r_pending   <= 1'b0;
      end else if (!en || w_apply) begin
         if (load)           r_disp <= s;
         else if (r_pending) r_disp <= r_pend_word;
         r_pending <= 1'b0;
      end else if (load) begin
         r_pend_word <= s;
         r_pending   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with REFRESH_DIV=8, BLANK_CYC=2: slot/frame
// timing, word buffering, enable handling and asynchronous reset.
module tb_seg_scan;

   localparam int RD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s;
   logic        load;
   logic        en;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame;
   logic        pending;

   int n_vec  = 0;
   int n_miss = 0;
   int k      = 0;   // edges since scanning started from idx=0,cnt=0

   seg_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
      .clk     (clk),
      .rst     (rst),
      .s       (s),
      .load    (load),
      .en      (en),
      .an      (an),
      .seg     (seg),
      .frame   (frame),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n edges; after edge k the outputs reflect scan state k-1.
   // The shown word is old_w for states before sw and new_w from sw on.
   task automatic scan(input string tag, input int n, input logic [31:0] old_w,
                       input logic [31:0] new_w, input int sw);
      int st, c, d;
      logic [31:0] w;
      logic [3:0]  ea;
      logic [7:0]  es;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         k++;
         st = k - 1;
         c  = st % RD;
         d  = (st / RD) % 4;
         w  = (st < sw) ? old_w : new_w;
         if (c < BC) begin
            ea = 4'b1111;
            es = 8'hFF;
         end else begin
            ea = ~(4'b0001 << d);
            es = w[8*d +: 8];
         end
         chk($sformatf("%s an k=%0d", tag, k), 32'(an), 32'(ea));
         chk($sformatf("%s seg k=%0d", tag, k), 32'(seg), 32'(es));
         chk($sformatf("%s frame k=%0d", tag, k), 32'(frame), 32'((st % 32) == 31));
      end
   endtask

   task automatic chk_blank(input string tag);
      chk({tag, " an"}, 32'(an), 32'h0000_000F);
      chk({tag, " seg"}, 32'(seg), 32'h0000_00FF);
      chk({tag, " frame"}, 32'(frame), 32'h0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; s = '0;
      #3;
      chk_blank("reset");
      chk("reset pending", 32'(pending), 32'h0);

      // Free-running scan of the reset word: everything off, frame every 32.
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1; k = 0;
      scan("idle", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      // Load while disabled goes straight to the display.
      en = 1'b0; load = 1'b1; s = 32'hFF11_D585;
      @(posedge clk); #1;
      load = 1'b0;
      chk_blank("en0 load");
      chk("en0 load pending", 32'(pending), 32'h0);
      en = 1'b1; k = 0;
      scan("direct", 32, 32'hFF11_D585, 32'hFF11_D585, 0);

      // Mid-frame load waits for the frame boundary.
      scan("mid", 10, 32'hFF11_D585, 32'h0123_4567, 64);
      load = 1'b1; s = 32'h0123_4567;
      scan("mid", 1, 32'hFF11_D585, 32'h0123_4567, 64);
      load = 1'b0;
      chk("mid pending set", 32'(pending), 32'h1);
      scan("mid", 20, 32'hFF11_D585, 32'h0123_4567, 64);
      chk("mid pending held", 32'(pending), 32'h1);
      scan("mid", 1, 32'hFF11_D585, 32'h0123_4567, 64);
      chk("mid pending clr", 32'(pending), 32'h0);
      scan("mid", 32, 32'hFF11_D585, 32'h0123_4567, 64);

      // Two loads in one frame: only the later one is ever shown.
      scan("ab", 4, 32'h0123_4567, 32'h5B6B_7B8B, 128);
      load = 1'b1; s = 32'hA1A2_A3A4;
      scan("ab", 1, 32'h0123_4567, 32'h5B6B_7B8B, 128);
      load = 1'b0;
      scan("ab", 9, 32'h0123_4567, 32'h5B6B_7B8B, 128);
      load = 1'b1; s = 32'h5B6B_7B8B;
      scan("ab", 1, 32'h0123_4567, 32'h5B6B_7B8B, 128);
      load = 1'b0;
      chk("ab pending set", 32'(pending), 32'h1);
      scan("ab", 17, 32'h0123_4567, 32'h5B6B_7B8B, 128);
      chk("ab pending clr", 32'(pending), 32'h0);

      // Load on the apply cycle (idx=3, cnt=7) bypasses pending.
      scan("apl", 31, 32'h5B6B_7B8B, 32'hC0C1_C2C3, 160);
      load = 1'b1; s = 32'hC0C1_C2C3;
      scan("apl", 1, 32'h5B6B_7B8B, 32'hC0C1_C2C3, 160);
      load = 1'b0;
      chk("apl pending", 32'(pending), 32'h0);
      scan("apl", 15, 32'h5B6B_7B8B, 32'hC0C1_C2C3, 160);

      // Pending word at en fall is committed; en drop at idx=2,cnt=5 blanks at once.
      load = 1'b1; s = 32'h1122_3344;
      scan("enf", 1, 32'hC0C1_C2C3, 32'hC0C1_C2C3, 0);
      load = 1'b0;
      chk("enf pending set", 32'(pending), 32'h1);
      scan("enf", 5, 32'hC0C1_C2C3, 32'hC0C1_C2C3, 0);
      en = 1'b0;
      @(posedge clk); #1;
      chk_blank("en drop");
      chk("en drop pending", 32'(pending), 32'h0);
      @(posedge clk); #1;
      chk_blank("en low");
      en = 1'b1; k = 0;
      scan("enr", 10, 32'h1122_3344, 32'h1122_3344, 0);

      // Asynchronous reset during DRIVE with a word pending.
      load = 1'b1; s = 32'h9999_9999;
      scan("rst", 1, 32'h1122_3344, 32'h1122_3344, 0);
      load = 1'b0;
      chk("rst pending pre", 32'(pending), 32'h1);
      scan("rst", 2, 32'h1122_3344, 32'h1122_3344, 0);
      #2 rst = 1'b1;
      #1;
      chk_blank("async rst");
      chk("async rst pending", 32'(pending), 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0; k = 0;
      scan("post", 40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("post pending", 32'(pending), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 16: dead-time cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 s  in  32  segment word: s[8k+7:8k] is digit k (k=0 rightmost), byte bit7..bit0 = {CA,CB,CC,CD,CE,CF,CG,DP}, active-low.
REQ-006 load  in  1  single-cycle strobe; capture s.
REQ-007 en  in  1  scan enable; 0 blanks the display.
REQ-008 an  out  4  digit anodes, active-low, an[k] selects digit k.
REQ-009 seg  out  8  cathodes {CA..CG,DP}, active-low.
REQ-010 frame  out  1  one-cycle pulse marking frame start, i.e. digit-0 slot start.
REQ-011 pending  out  1  high while a captured word awaits display.

Function
REQ-012 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index idx SHALL advance 0->1->2->3->0 on each wrap.
REQ-013 FSM states per slot: BLANK (cnt < BLANK_CYC) and DRIVE (cnt >= BLANK_CYC); BLANK->DRIVE at cnt==BLANK_CYC; DRIVE->BLANK at slot wrap.
REQ-014 In BLANK, an SHALL be 4'b1111 and seg 8'hFF; in DRIVE, an SHALL have only bit idx low and seg SHALL equal disp[8*idx+7:8*idx].
REQ-015 an, seg and frame SHALL be registered and lag the (idx,cnt) state by exactly one cycle.
REQ-016 load=1 SHALL capture s into a pending register and set pending, unless the same cycle is an apply cycle (REQ-018).
REQ-017 Multiple loads before an apply SHALL keep only the last word.
REQ-018 Apply cycle = cycle where idx==3 and cnt==REFRESH_DIV-1 while en=1; on it, disp SHALL take the pending word when pending=1, and pending SHALL clear.
REQ-019 load asserted on an apply cycle SHALL write s directly into disp; this word overrides any older pending word, and pending SHALL end at 0.
REQ-020 frame SHALL pulse high for one cycle following every apply cycle, whether or not pending was set.
REQ-021 disp SHALL never change mid-frame while en=1; no digit of one frame shows a mix of two words.
REQ-022 en=0: an=4'b1111, seg=8'hFF, frame=0; cnt and idx SHALL be held at 0 and the FSM in BLANK; load SHALL write s directly into disp with pending=0; a pending word present at en fall SHALL be moved into disp in that cycle.
REQ-023 en 0->1 SHALL start scanning at idx=0, cnt=0 (BLANK); the first frame pulse follows the first apply cycle.
REQ-024 en falling mid-slot SHALL blank outputs on the next cycle, with no partial DRIVE continuing.

Reset
REQ-025 rst=1 SHALL asynchronously force an=4'b1111, seg=8'hFF, frame=0, pending=0, disp=32'hFFFF_FFFF, pending register=32'hFFFF_FFFF, cnt=0, idx=0, FSM=BLANK.
REQ-026 Reset asserted mid-slot or mid-frame SHALL discard any pending word; after release, scanning resumes per REQ-023 when en=1.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-027 rst pulse, en=1, no load -> an cycles 1110,1101,1011,0111; each slot has 2 cycles of an=1111 and then 6 cycles driving; seg=FF throughout; frame pulses every 32 cycles.
REQ-028 en=0, load s=32'hFF11_D585 -> next cycles, with en=1: digit0 seg=85, digit1 D5, digit2 11, digit3 FF, each on its own anode only in DRIVE.
REQ-029 mid-frame (idx=1) load s=32'h0123_4567 -> pending=1; digits 1..3 keep the old word until the frame ends; the frame pulse follows the apply cycle; then digit0 shows 67 and pending=0.
REQ-030 two loads A then B in the same frame -> only B is displayed; A never appears on seg; load on an apply cycle -> shown next frame, pending stays 0.
REQ-031 en dropped at idx=2, cnt=5 -> an=1111, seg=FF next cycle; en raised -> an=1111 for 2 cycles, then 1110.
REQ-032 rst asserted between clock edges during DRIVE with pending=1 -> outputs go off immediately, without waiting for a clock edge; pending=0; displayed word is all-off after release.
